// File: rtl/payload_demap.sv
// Receive-side frame demapper: locks to FAS, tracks row/column, strips overhead/stuff columns,
// buffers payload in a FWFT FIFO and extracts ARQ_EN. Define PAYLOAD_DEMAP_ARQ_FILTER_EN for filtering.
module payload_demap #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 1041,
  parameter int unsigned OH_COLS    = 16,
  parameter int unsigned STUFF_COL  = 1040,
  parameter int unsigned ARQ_COL    = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_frame_data,
  input  logic                     i_frame_data_valid,
  input  logic                     i_frame_data_fas,
  output logic [7:0]               o_pyld_data,
  output logic                     o_pyld_data_valid,
  input  logic                     i_pyld_ready,
  output logic                     o_arq_en,
  output logic                     o_arq_en_valid,
  output logic                     o_lof,
  output logic                     o_ovf,
  output logic [$clog2(ROWS)-1:0]  o_row_cnt,
  output logic [$clog2(COLS)-1:0]  o_col_cnt
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {StHunt, StSync} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d, exp_row;
  logic [ColW-1:0]   col_q, col_d, exp_col;
  logic [1:0]        miss_q, miss_d, miss_nxt;
  logic              take, at_zero, push, push_ok, pop, full, ovf_set, arq_hit, raw;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     cnt_q;
  logic              arq_en_q, arq_en_d, arq_vld_q, ovf_q;

  // Position the next valid byte would occupy if alignment holds.
  always_comb begin
    exp_col = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
    exp_row = row_q;
    if (col_q == ColW'(COLS - 1)) begin
      exp_row = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end
    at_zero = (exp_row == '0) && (exp_col == '0);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    miss_d   = miss_q;
    miss_nxt = miss_q;
    take     = 1'b0;
    if (i_frame_data_valid) begin
      unique case (state_q)
        StHunt: begin
          row_d = exp_row;
          col_d = exp_col;
          if (i_frame_data_fas) begin
            row_d   = '0;
            col_d   = '0;
            miss_d  = '0;
            state_d = StSync;
            take    = 1'b1;
          end
        end
        StSync: begin
          if (i_frame_data_fas) begin
            row_d    = '0;
            col_d    = '0;
            miss_nxt = at_zero ? 2'd0 : miss_q + 2'd1;
          end else begin
            row_d    = exp_row;
            col_d    = exp_col;
            miss_nxt = at_zero ? miss_q + 2'd1 : miss_q;
          end
          if (miss_nxt == 2'd2) begin
            state_d = StHunt;
            miss_d  = '0;
          end else begin
            miss_d = miss_nxt;
            take   = 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    push    = take && (col_d >= ColW'(OH_COLS)) && (col_d != ColW'(STUFF_COL));
    arq_hit = take && (row_d == '0) && (col_d == ColW'(ARQ_COL));
    raw     = &i_frame_data;
    full    = (cnt_q == (PtrW + 1)'(FIFO_DEPTH));
    pop     = (cnt_q != '0) && i_pyld_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok = push && (!full || pop);
    ovf_set = push && full && !pop;
  end

`ifdef PAYLOAD_DEMAP_ARQ_FILTER_EN
  logic hist_vld_q, hist_q;

  always_comb begin
    arq_en_d = arq_en_q;
    if (arq_hit && (!hist_vld_q || (raw == hist_q))) begin
      arq_en_d = raw;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hist_vld_q <= 1'b0;
      hist_q     <= 1'b0;
    end else if (state_q == StSync && state_d == StHunt) begin
      hist_vld_q <= 1'b0;
    end else if (arq_hit) begin
      hist_vld_q <= 1'b1;
      hist_q     <= raw;
    end
  end
`else
  always_comb begin
    arq_en_d = arq_en_q;
    if (arq_hit) begin
      arq_en_d = raw;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StHunt;
      row_q     <= '0;
      col_q     <= '0;
      miss_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      arq_en_q  <= 1'b0;
      arq_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      miss_q    <= miss_d;
      arq_en_q  <= arq_en_d;
      arq_vld_q <= arq_hit;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_frame_data;
    end
  end

  assign o_pyld_data       = (cnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign o_pyld_data_valid = (cnt_q != '0);
  assign o_arq_en          = arq_en_q;
  assign o_arq_en_valid    = arq_vld_q;
  assign o_lof             = (state_q == StHunt);
  assign o_ovf             = ovf_q;
  assign o_row_cnt         = row_q;
  assign o_col_cnt         = col_q;

endmodule

// File: tb/tb_payload_demap.sv
// Randomized self-checking bench for payload_demap; expected payload comes from a frame-index
// model with a queue-based FIFO occupancy model.
module tb_payload_demap;

  localparam int ROWS  = 4;
  localparam int COLS  = 1041;
  localparam int FRAME = ROWS * COLS;
  localparam int OH    = 16;
  localparam int STUFF = 1040;
  localparam int ARQ   = 6;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fd;
  logic       fv, ffas, rdy;
  logic [7:0] pd;
  logic       pv, arq, arqv, lof, ovf;
  logic [1:0] rowc;
  logic [10:0] colc;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q [$];
  int rx_cnt;
  bit m_hunt;
  int m_idx;
  int m_miss;
  bit m_ovf;

  always #5 clk = ~clk;

  payload_demap dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_frame_data       (fd),
    .i_frame_data_valid (fv),
    .i_frame_data_fas   (ffas),
    .o_pyld_data        (pd),
    .o_pyld_data_valid  (pv),
    .i_pyld_ready       (rdy),
    .o_arq_en           (arq),
    .o_arq_en_valid     (arqv),
    .o_lof              (lof),
    .o_ovf              (ovf),
    .o_row_cnt          (rowc),
    .o_col_cnt          (colc)
  );

  // Every accepted head must be the oldest byte the model expects.
  always @(negedge clk) begin
    if (!rst && pv && rdy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pyld_unexpected got %02h want no data", pd);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (pd !== e) begin
          miscompares++;
          $display("FAIL pyld_data got %02h want %02h (rx %0d)", pd, e, rx_cnt);
        end
        rx_cnt++;
      end
    end
  end

  // Frame model on a linear in-frame index; FIFO modelled by the expected-data queue.
  task automatic model_byte(input logic [7:0] d, input bit fas);
    bit take = 0;
    bit pop_now;
    int nxt;
    if (m_hunt) begin
      if (fas) begin
        m_hunt = 0; m_idx = 0; m_miss = 0; take = 1;
      end
    end else begin
      nxt = (m_idx + 1) % FRAME;
      if (fas) begin
        m_miss = (nxt == 0) ? 0 : m_miss + 1;
        m_idx  = 0;
      end else begin
        m_idx = nxt;
        if (nxt == 0) m_miss++;
      end
      if (m_miss >= 2) begin
        m_hunt = 1; m_miss = 0;
      end else begin
        take = 1;
      end
    end
    if (take && (m_idx % COLS) >= OH && (m_idx % COLS) != STUFF) begin
      pop_now = rdy && (exp_q.size() > 0);
      if (exp_q.size() >= DEPTH && !pop_now) m_ovf = 1;
      else exp_q.push_back(d);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit fas);
    fd = d; ffas = fas; fv = 1'b1;
    model_byte(d, fas);
    @(posedge clk); #1;
    fv = 1'b0; ffas = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input bit fas_first,
                            input logic [7:0] arq_byte);
    for (int i = first; i <= last; i++) begin
      send_byte((i == ARQ) ? arq_byte : 8'($urandom), fas_first && (i == first));
    end
  endtask

  task automatic idle(input int n);
    fv = 1'b0; ffas = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fv = 1'b0; ffas = 1'b0; fd = 8'h00; rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_hunt = 1; m_idx = 0; m_miss = 0; m_ovf = 0; rx_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({lof, pv, pd, arq, arqv, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_flags got lof=%b v=%b d=%02h arq=%b arqv=%b ovf=%b", lof, pv, pd, arq,
               arqv, ovf);
    end
    vectors++;
    if (rowc !== 2'd0 || colc !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_pos got %0d/%0d want 0/0", rowc, colc);
    end
  endtask

  task automatic test_lock_strip();
    do_reset();
    send_range(100, 150, 0, 8'($urandom));
    vectors++;
    if (lof !== 1'b1 || pv !== 1'b0) begin
      miscompares++;
      $display("FAIL hunt_discard got lof=%b v=%b want 1/0", lof, pv);
    end
    send_range(0, 0, 1, 8'($urandom));
    vectors++;
    if (lof !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_lof got %b want 0", lof);
    end
    send_range(1, 2582, 0, 8'($urandom));
    vectors++;
    if (rowc !== 2'd2 || colc !== 11'd500) begin
      miscompares++;
      $display("FAIL lock_pos got %0d/%0d want 2/500", rowc, colc);
    end
    send_range(2583, FRAME - 1, 0, 8'($urandom));
    send_range(0, FRAME - 1, 1, 8'($urandom));
    idle(4);
    vectors++;
    if (rx_cnt !== 8192 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL lock_count got %0d (left %0d) want 8192", rx_cnt, exp_q.size());
    end
  endtask

  task automatic test_arq();
    logic [7:0] b [3];
    logic       e [3];
    b = '{8'hFF, 8'hFE, 8'hFE};
`ifdef PAYLOAD_DEMAP_ARQ_FILTER_EN
    e = '{1'b1, 1'b1, 1'b0};
`else
    e = '{1'b1, 1'b0, 1'b0};
`endif
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_range(0, 5, 1, 8'h00);
      send_byte(b[k], 0);
      vectors++;
      if (arqv !== 1'b1 || arq !== e[k]) begin
        miscompares++;
        $display("FAIL arq_update frame %0d got v=%b en=%b want 1/%b", k, arqv, arq, e[k]);
      end
      send_byte(8'($urandom), 0);
      vectors++;
      if (arqv !== 1'b0 || arq !== e[k]) begin
        miscompares++;
        $display("FAIL arq_hold frame %0d got v=%b en=%b want 0/%b", k, arqv, arq, e[k]);
      end
      send_range(8, FRAME - 1, 0, 8'h00);
    end
    idle(10);
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send_range(0, 15, 1, 8'($urandom));
    rdy = 1'b0;
    send_range(16, 23, 0, 8'($urandom));
    vectors++;
    if (pv !== 1'b1 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_fill got v=%b ovf=%b want 1/0", pv, ovf);
    end
    rdy = 1'b1;
    send_range(24, 40, 0, 8'($urandom));
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_push_pop_ovf got %b want 0", ovf);
    end
    idle(12);
    vectors++;
    if (exp_q.size() != 0 || rx_cnt !== 25) begin
      miscompares++;
      $display("FAIL full_drain got rx=%0d left=%0d want 25/0", rx_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_range(0, 15, 1, 8'($urandom));
    rdy = 1'b0;
    send_range(16, 35, 0, 8'($urandom));
    vectors++;
    if (ovf !== 1'b1 || ovf !== m_ovf || pv !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ovf got ovf=%b v=%b want 1/1", ovf, pv);
    end
    rdy = 1'b1;
    idle(12);
    vectors++;
    if (rx_cnt !== 8 || pv !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_buffered got %0d v=%b want 8/0", rx_cnt, pv);
    end
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_sticky got %b want 1", ovf);
    end
  endtask

  task automatic test_lost_frame();
    int rx_before;
    do_reset();
    send_range(0, FRAME - 1, 1, 8'($urandom));
    send_range(0, 0, 0, 8'($urandom));
    vectors++;
    if (lof !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_first_miss got lof=%b want 0", lof);
    end
    send_range(1, FRAME - 1, 0, 8'($urandom));
    send_range(0, 0, 0, 8'($urandom));
    vectors++;
    if (lof !== 1'b1) begin
      miscompares++;
      $display("FAIL lost_lof got %b want 1", lof);
    end
    idle(12);
    rx_before = rx_cnt;
    send_range(1, FRAME - 1, 0, 8'($urandom));
    idle(4);
    vectors++;
    if (rx_cnt !== rx_before || pv !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_no_payload got rx=%0d v=%b want %0d/0", rx_cnt, pv, rx_before);
    end
    send_range(0, 0, 1, 8'($urandom));
    vectors++;
    if (lof !== 1'b0) begin
      miscompares++;
      $display("FAIL relock_lof got %b want 0", lof);
    end
    send_range(1, FRAME - 1, 0, 8'($urandom));
    idle(12);
    vectors++;
    if (rx_cnt !== rx_before + 4096 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL relock_count got %0d want %0d", rx_cnt, rx_before + 4096);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    send_range(0, 2581, 1, 8'($urandom));
    send_range(2582, 2582, 1, 8'($urandom));
    vectors++;
    if (rowc !== 2'd0 || colc !== 11'd0 || lof !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_pos got %0d/%0d lof=%b want 0/0/0", rowc, colc, lof);
    end
    send_range(1, FRAME - 1, 0, 8'($urandom));
    send_range(0, 0, 1, 8'($urandom));
    vectors++;
    if (lof !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_ontime got lof=%b want 0", lof);
    end
    send_range(1, FRAME - 1, 0, 8'($urandom));
    send_range(0, 0, 0, 8'($urandom));
    vectors++;
    if (lof !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_cleared got lof=%b want 0", lof);
    end
    // One miss pending; a misaligned FAS is the second and must drop lock.
    send_range(1, 1000, 0, 8'($urandom));
    send_range(1001, 1001, 1, 8'($urandom));
    vectors++;
    if (lof !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_second_miss got lof=%b want 1", lof);
    end
    idle(12);
    vectors++;
    if (exp_q.size() != 0 || pv !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_drain left=%0d v=%b want 0/0", exp_q.size(), pv);
    end
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; ffas = 1'b0; fd = 8'h00; rdy = 1'b1;
    test_reset();
    test_lock_strip();
    test_arq();
    test_full_push_pop();
    test_backpressure();
    test_lost_frame();
    test_misaligned();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
